// File: rtl/uart_reg_responder.sv
// -----------------------------------------------------------------------------
// uart_reg_responder
//
// Host-side peer of a UART core. Collects received bytes into register-access
// frames (SYNC, CMD, ADDR[, DATA]), performs one register bus access and sends
// a one-byte reply through the transmitter handshake.
//
//   CMD 8'h01 : write ADDR <= DATA, reply ACK_BYTE
//   CMD 8'h02 : read ADDR, reply with the read data
//   other     : no bus access, reply NAK_BYTE
//
// Optional feature, macro UART_REG_RESP_CSUM_EN:
//   Each frame carries a trailing CSUM byte equal to CMD ^ ADDR (^ DATA for
//   writes). A mismatch suppresses the bus access and the reply is NAK_BYTE.
//   Without the macro the frame ends at DATA (write) or ADDR (read/unknown).
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   rx_data    : received byte, valid while rx_done is high
//   rx_done    : one-cycle pulse per received byte
//   tx_start   : one-cycle pulse requesting transmission of tx_data
//   tx_data    : reply byte, held from tx_start until tx_done
//   tx_done    : one-cycle pulse when the transmitter has finished
//   bus_wr     : one-cycle register write strobe
//   bus_rd     : one-cycle register read strobe
//   bus_addr   : register address
//   bus_wdata  : register write data
//   bus_rdata  : register read data, valid the cycle after bus_rd
//   busy       : high whenever a frame or reply is in progress
//   frame_err  : one-cycle pulse when a frame is abandoned on inter-byte timeout
// -----------------------------------------------------------------------------
module uart_reg_responder #(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter logic [7:0]  ACK_BYTE    = 8'h06,
    parameter logic [7:0]  NAK_BYTE    = 8'h15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic       bus_wr,
    output logic       bus_rd,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    output logic       busy,
    output logic       frame_err
);

    localparam logic [7:0] CmdWrite = 8'h01;
    localparam logic [7:0] CmdRead  = 8'h02;

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    // The counter restarts at 0 the cycle after an accepted byte, so the cycle
    // in which it would step to TIMEOUT_CYC-1 is the expiry cycle.
    localparam logic [CntW-1:0] CntExpire = CntW'(TIMEOUT_CYC - 2);

    typedef enum logic [3:0] {
        StIdle,
        StGetCmd,
        StGetAddr,
        StGetData,
`ifdef UART_REG_RESP_CSUM_EN
        StGetCsum,
`endif
        StExec,
        StRdWait,
        StSend,
        StWaitDone
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [7:0]      bus_addr_q, bus_addr_d;
    logic [7:0]      bus_wdata_q, bus_wdata_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic in_get;
    logic timeout_hit;
    logic csum_ok;
    logic cmd_is_wr;
    logic cmd_is_rd;

`ifdef UART_REG_RESP_CSUM_EN
    logic       csum_ok_q, csum_ok_d;
    logic [7:0] csum_exp;

    assign csum_exp = cmd_q ^ bus_addr_q ^ (cmd_is_wr ? bus_wdata_q : 8'h00);
    assign csum_ok  = csum_ok_q;
`else
    assign csum_ok  = 1'b1;
`endif

    assign cmd_is_wr = (cmd_q == CmdWrite);
    assign cmd_is_rd = (cmd_q == CmdRead);

    // Frame-collection states are the only ones covered by the timeout.
    always_comb begin
        in_get = 1'b0;
        unique case (state_q)
            StGetCmd, StGetAddr, StGetData: in_get = 1'b1;
`ifdef UART_REG_RESP_CSUM_EN
            StGetCsum:                      in_get = 1'b1;
`endif
            default:                        in_get = 1'b0;
        endcase
    end

    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign timeout_hit = in_get && !rx_done && (cnt_q == CntExpire);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (rx_done && (rx_data == SYNC_BYTE)) begin
                    state_d = StGetCmd;
                end
            end
            StGetCmd: begin
                if (rx_done) begin
                    state_d = StGetAddr;
                end else if (timeout_hit) begin
                    state_d = StIdle;
                end
            end
            StGetAddr: begin
                if (rx_done) begin
                    if (cmd_is_wr) begin
                        state_d = StGetData;
                    end else begin
`ifdef UART_REG_RESP_CSUM_EN
                        state_d = StGetCsum;
`else
                        state_d = StExec;
`endif
                    end
                end else if (timeout_hit) begin
                    state_d = StIdle;
                end
            end
            StGetData: begin
                if (rx_done) begin
`ifdef UART_REG_RESP_CSUM_EN
                    state_d = StGetCsum;
`else
                    state_d = StExec;
`endif
                end else if (timeout_hit) begin
                    state_d = StIdle;
                end
            end
`ifdef UART_REG_RESP_CSUM_EN
            StGetCsum: begin
                if (rx_done) begin
                    state_d = StExec;
                end else if (timeout_hit) begin
                    state_d = StIdle;
                end
            end
`endif
            StExec: begin
                state_d = (csum_ok && cmd_is_rd) ? StRdWait : StSend;
            end
            StRdWait: begin
                state_d = StSend;
            end
            StSend: begin
                state_d = StWaitDone;
            end
            StWaitDone: begin
                if (tx_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q       <= 8'h00;
            bus_addr_q  <= 8'h00;
            bus_wdata_q <= 8'h00;
            tx_data_q   <= 8'h00;
            cnt_q       <= '0;
`ifdef UART_REG_RESP_CSUM_EN
            csum_ok_q   <= 1'b0;
`endif
        end else begin
            cmd_q       <= cmd_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            tx_data_q   <= tx_data_d;
            cnt_q       <= cnt_d;
`ifdef UART_REG_RESP_CSUM_EN
            csum_ok_q   <= csum_ok_d;
`endif
        end
    end

    always_comb begin
        cmd_d       = cmd_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        tx_data_d   = tx_data_q;
`ifdef UART_REG_RESP_CSUM_EN
        csum_ok_d   = csum_ok_q;
`endif

        // Counts idle cycles inside a frame; zero everywhere else.
        if (in_get && !rx_done && !timeout_hit) begin
            cnt_d = cnt_q + CntW'(1);
        end else begin
            cnt_d = '0;
        end

        unique case (state_q)
            StGetCmd: begin
                if (rx_done) cmd_d = rx_data;
            end
            StGetAddr: begin
                if (rx_done) bus_addr_d = rx_data;
            end
            StGetData: begin
                if (rx_done) bus_wdata_d = rx_data;
            end
`ifdef UART_REG_RESP_CSUM_EN
            StGetCsum: begin
                if (rx_done) csum_ok_d = (rx_data == csum_exp);
            end
`endif
            StExec: begin
                if (csum_ok && cmd_is_wr) begin
                    tx_data_d = ACK_BYTE;
                end else if (!(csum_ok && cmd_is_rd)) begin
                    tx_data_d = NAK_BYTE;
                end
            end
            StRdWait: begin
                tx_data_d = bus_rdata;
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy      = (state_q != StIdle);
        tx_start  = (state_q == StSend);
        bus_wr    = (state_q == StExec) && csum_ok && cmd_is_wr;
        bus_rd    = (state_q == StExec) && csum_ok && cmd_is_rd;
        frame_err = timeout_hit;
        tx_data   = tx_data_q;
        bus_addr  = bus_addr_q;
        bus_wdata = bus_wdata_q;
    end

endmodule

// File: tb/tb_uart_reg_responder.sv
// -----------------------------------------------------------------------------
// Testbench for uart_reg_responder. Expected reply bytes are queued when a
// frame is sent and popped by a monitor whenever tx_start is seen. Each
// scenario task checks its own cycle-exact expectations.
// Build with UART_REG_RESP_CSUM_EN defined to exercise the checksum frames.
// -----------------------------------------------------------------------------
module tb_uart_reg_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done = 1'b0;
    logic       bus_wr;
    logic       bus_rd;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata = 8'h00;
    logic       busy;
    logic       frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int start_cnt = 0;
    logic [7:0] exp_q[$];

    uart_reg_responder #(
        .TIMEOUT_CYC (50)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .bus_wr    (bus_wr),
        .bus_rd    (bus_rd),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Reply scoreboard and strobe bookkeeping.
    always @(negedge clk) begin
        if (bus_wr === 1'b1) wr_cnt++;
        if (bus_rd === 1'b1) rd_cnt++;
        if (bus_wr === 1'b1 || bus_rd === 1'b1) begin
            n_cmp++;
            if (bus_wr === 1'b1 && bus_rd === 1'b1) begin
                n_bad++;
                $display("FAIL strobe_overlap: bus_wr and bus_rd both high at %0t", $time);
            end
        end
        if (tx_start === 1'b1) begin
            start_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_reply: got %02h, expected no reply", tx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    n_bad++;
                    $display("FAIL reply_data: got %02h, expected %02h", tx_data, e);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [28:0] out_vec();
        return {tx_start, bus_wr, bus_rd, busy, frame_err, tx_data, bus_addr, bus_wdata};
    endfunction

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr,
                              input logic [7:0] data, input bit has_data);
        send_byte(8'hA5);
        send_byte(cmd);
        send_byte(addr);
        if (has_data) send_byte(data);
`ifdef UART_REG_RESP_CSUM_EN
        send_byte(cmd ^ addr ^ (has_data ? data : 8'h00));
`endif
    endtask

    task automatic release_tx();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        @(negedge clk);
        n_cmp++;
        if (out_vec() !== 29'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %08h, expected 00000000", out_vec());
        end
        rst = 1'b0;
        step();
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_busy: got %b, expected 0", busy);
        end
        step();
    endtask

    task automatic test_write();
        int w0;
        w0 = wr_cnt;
        exp_q.push_back(8'h06);
        send_frame(8'h01, 8'h3C, 8'h5A, 1'b1);
        @(negedge clk);  // N+1: EXEC
        n_cmp++;
        if ({bus_wr, bus_rd, bus_addr, bus_wdata} !== {1'b1, 1'b0, 8'h3C, 8'h5A}) begin
            n_bad++;
            $display("FAIL write_strobe: wr=%b rd=%b addr=%02h wdata=%02h, expected 1 0 3c 5a",
                     bus_wr, bus_rd, bus_addr, bus_wdata);
        end
        step();
        @(negedge clk);  // N+2: SEND
        n_cmp++;
        if ({tx_start, tx_data} !== {1'b1, 8'h06}) begin
            n_bad++;
            $display("FAIL write_tx_start: start=%b data=%02h, expected 1 06", tx_start, tx_data);
        end
        step();
        @(negedge clk);  // N+3: WAIT_DONE
        n_cmp++;
        if ({tx_start, busy, tx_data} !== {1'b0, 1'b1, 8'h06}) begin
            n_bad++;
            $display("FAIL write_wait_done: start=%b busy=%b data=%02h, expected 0 1 06",
                     tx_start, busy, tx_data);
        end
        release_tx();
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL write_busy_clear: got %b, expected 0", busy);
        end
        n_cmp++;
        if (wr_cnt !== w0 + 1) begin
            n_bad++;
            $display("FAIL write_strobe_count: got %0d, expected %0d", wr_cnt - w0, 1);
        end
        step();
    endtask

    task automatic test_read();
        int r0;
        r0 = rd_cnt;
        exp_q.push_back(8'hC3);
        bus_rdata = 8'h00;
        send_frame(8'h02, 8'h10, 8'h00, 1'b0);
        @(negedge clk);  // N+1: EXEC
        n_cmp++;
        if ({bus_rd, bus_wr, bus_addr} !== {1'b1, 1'b0, 8'h10}) begin
            n_bad++;
            $display("FAIL read_strobe: rd=%b wr=%b addr=%02h, expected 1 0 10",
                     bus_rd, bus_wr, bus_addr);
        end
        step();
        bus_rdata = 8'hC3;  // only valid during RD_WAIT
        @(negedge clk);  // N+2: RD_WAIT
        n_cmp++;
        if ({tx_start, busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL read_rd_wait: start=%b busy=%b, expected 0 1", tx_start, busy);
        end
        step();
        bus_rdata = 8'h77;
        @(negedge clk);  // N+3: SEND
        n_cmp++;
        if ({tx_start, tx_data} !== {1'b1, 8'hC3}) begin
            n_bad++;
            $display("FAIL read_tx_start: start=%b data=%02h, expected 1 c3", tx_start, tx_data);
        end
        step();
        release_tx();
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || rd_cnt !== r0 + 1) begin
            n_bad++;
            $display("FAIL read_done: busy=%b strobes=%0d, expected 0 1", busy, rd_cnt - r0);
        end
        step();
    endtask

    task automatic test_junk_unknown();
        int w0;
        int r0;
        w0 = wr_cnt;
        r0 = rd_cnt;
        send_byte(8'h00);
        send_byte(8'hFF);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL junk_dropped: busy=%b, expected 0", busy);
        end
        step();
        exp_q.push_back(8'h15);
        send_frame(8'h07, 8'h20, 8'h00, 1'b0);
        @(negedge clk);  // N+1: EXEC
        n_cmp++;
        if ({bus_wr, bus_rd, busy, tx_start} !== 4'b0010) begin
            n_bad++;
            $display("FAIL unknown_exec: wr=%b rd=%b busy=%b start=%b, expected 0 0 1 0",
                     bus_wr, bus_rd, busy, tx_start);
        end
        step();
        @(negedge clk);  // N+2: SEND
        n_cmp++;
        if ({tx_start, tx_data} !== {1'b1, 8'h15}) begin
            n_bad++;
            $display("FAIL unknown_reply: start=%b data=%02h, expected 1 15", tx_start, tx_data);
        end
        step();
        release_tx();
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || wr_cnt !== w0 || rd_cnt !== r0) begin
            n_bad++;
            $display("FAIL unknown_no_strobe: busy=%b wr=%0d rd=%0d, expected 0 0 0",
                     busy, wr_cnt - w0, rd_cnt - r0);
        end
        step();
    endtask

    task automatic test_timeout();
        int s0;
        int first;
        int pulses;
        bit got;
        s0 = start_cnt;
        first = -1;
        pulses = 0;
        send_byte(8'hA5);
        send_byte(8'h01);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (frame_err === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
            step();
        end
        @(negedge clk);
        n_cmp++;
        if (first !== 49) begin
            n_bad++;
            $display("FAIL timeout_latency: frame_err after %0d cycles, expected 49", first);
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL timeout_pulse_width: got %0d cycles, expected 1", pulses);
        end
        n_cmp++;
        if (busy !== 1'b0 || start_cnt !== s0) begin
            n_bad++;
            $display("FAIL timeout_idle: busy=%b replies=%0d, expected 0 0",
                     busy, start_cnt - s0);
        end
        step();
        bus_rdata = 8'h5E;
        exp_q.push_back(8'h5E);
        send_frame(8'h02, 8'h10, 8'h00, 1'b0);
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (tx_start === 1'b1) got = 1'b1;
            else step();
        end
        n_cmp++;
        if (got !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_recovery: tx_start seen=%b, expected 1", got);
        end
        step();
        release_tx();
        step();
    endtask

    task automatic test_reset_in_wait_done();
        exp_q.push_back(8'h06);
        send_frame(8'h01, 8'h3C, 8'h5A, 1'b1);
        step();
        step();
        @(negedge clk);  // WAIT_DONE
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_pre_busy: got %b, expected 1", busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_vec() !== 29'h0) begin
            n_bad++;
            $display("FAIL rst_wait_done_outputs: got %08h, expected 00000000", out_vec());
        end
        step();
    endtask

    task automatic test_drop_in_wait_done();
        exp_q.push_back(8'h06);
        send_frame(8'h01, 8'h81, 8'h7E, 1'b1);
        step();
        step();  // WAIT_DONE
        send_byte(8'hA5);
        @(negedge clk);
        n_cmp++;
        if ({busy, tx_start} !== 2'b10) begin
            n_bad++;
            $display("FAIL drop_wait_done: busy=%b start=%b, expected 1 0", busy, tx_start);
        end
        release_tx();
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_busy_clear: got %b, expected 0", busy);
        end
        step();
        bus_rdata = 8'h9A;
        exp_q.push_back(8'h9A);
        send_frame(8'h02, 8'hA5, 8'h00, 1'b0);  // SYNC value as address is payload
        @(negedge clk);
        n_cmp++;
        if ({bus_rd, bus_addr} !== {1'b1, 8'hA5}) begin
            n_bad++;
            $display("FAIL drop_next_read: rd=%b addr=%02h, expected 1 a5", bus_rd, bus_addr);
        end
        step();
        step();
        @(negedge clk);
        n_cmp++;
        if (tx_start !== 1'b1) begin
            n_bad++;
            $display("FAIL drop_next_reply: start=%b, expected 1", tx_start);
        end
        step();
        release_tx();
        step();
    endtask

`ifdef UART_REG_RESP_CSUM_EN
    task automatic test_csum();
        int w0;
        w0 = wr_cnt;
        // 01 ^ 3C ^ 5A = 67 is the correct checksum; 66 is one bit off.
        exp_q.push_back(8'h06);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h3C);
        send_byte(8'h5A);
        send_byte(8'h67);
        @(negedge clk);
        n_cmp++;
        if (bus_wr !== 1'b1) begin
            n_bad++;
            $display("FAIL csum_good_strobe: got %b, expected 1", bus_wr);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if ({tx_start, tx_data} !== {1'b1, 8'h06}) begin
            n_bad++;
            $display("FAIL csum_good_reply: start=%b data=%02h, expected 1 06", tx_start, tx_data);
        end
        step();
        release_tx();
        step();
        exp_q.push_back(8'h15);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h3C);
        send_byte(8'h5A);
        send_byte(8'h66);
        @(negedge clk);
        n_cmp++;
        if (bus_wr !== 1'b0) begin
            n_bad++;
            $display("FAIL csum_bad_strobe: got %b, expected 0", bus_wr);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if ({tx_start, tx_data} !== {1'b1, 8'h15}) begin
            n_bad++;
            $display("FAIL csum_bad_reply: start=%b data=%02h, expected 1 15", tx_start, tx_data);
        end
        step();
        release_tx();
        step();
        n_cmp++;
        if (wr_cnt !== w0 + 1) begin
            n_bad++;
            $display("FAIL csum_strobe_count: got %0d, expected 1", wr_cnt - w0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_junk_unknown();
        test_timeout();
        test_reset_in_wait_done();
        test_drop_in_wait_done();
`ifdef UART_REG_RESP_CSUM_EN
        test_csum();
`endif
        repeat (3) step();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d replies outstanding, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
